// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: FETCH, DECODE, EXEC, MEM, WB (+TRAP).
// Optional macro ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_src,
  output logic        alu_b_src,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_src,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state_reg;
  logic [6:0] opcode;
  logic       known;
  logic       to_wb;

  assign opcode = instr[6:0];

  always_comb begin
    known = 1'b1;
    to_wb = 1'b0;
    case (opcode)
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: to_wb = 1'b1;
      OP_LOAD, OP_STORE, OP_BRANCH, OP_FENCE: ;
      default: known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
`ifdef ILLEGAL_TRAP_EN
        S_DECODE: state_reg <= known ? S_EXEC : S_TRAP;
`else
        S_DECODE: state_reg <= S_EXEC;
`endif
        S_EXEC: begin
          if (to_wb)                                    state_reg <= S_WB;
          else if (opcode == OP_LOAD || opcode == OP_STORE) state_reg <= S_MEM;
          else                                          state_reg <= S_FETCH;
        end
        S_MEM:    if (mem_ready) state_reg <= (opcode == OP_STORE) ? S_FETCH : S_WB;
        S_WB:     state_reg <= S_FETCH;
        S_TRAP:   state_reg <= S_TRAP;
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the current state; mem_ready and branch_taken gate the final-cycle strobes.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_src    = 2'd0;
    alu_b_src    = 1'b0;
    alu_op       = 2'd0;
    rf_we        = 1'b0;
    wb_src       = 2'd0;
    illegal      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OP_OP:     alu_op = 2'd2;
          OP_OPIMM:  begin alu_b_src = 1'b1; alu_op = 2'd2; end
          OP_LUI:    begin alu_a_src = 2'd2; alu_b_src = 1'b1; end
          OP_AUIPC,
          OP_JAL:    begin alu_a_src = 2'd1; alu_b_src = 1'b1; end
          OP_JALR,
          OP_LOAD,
          OP_STORE:  alu_b_src = 1'b1;
          OP_BRANCH: begin
            alu_op = 2'd1;
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'd1 : 2'd0;
          end
          default:   pc_we = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (opcode == OP_STORE);
        pc_we        = mem_ready && (opcode == OP_STORE);
      end
      S_WB: begin
        rf_we = (instr[11:7] != 5'd0);
        pc_we = 1'b1;
        if (opcode == OP_LOAD)      wb_src = 2'd1;
        else if (opcode == OP_JAL || opcode == OP_JALR) wb_src = 2'd2;
        if (opcode == OP_JAL)       pc_src = 2'd1;
        else if (opcode == OP_JALR) pc_src = 2'd2;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  illegal = 1'b1;
`endif
      default: ;
    endcase
    // Reset overrides everything so an aborted instruction cannot write PC, IR or the register file.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      alu_a_src    = 2'd0;
      alu_b_src    = 1'b0;
      alu_op       = 2'd0;
      rf_we        = 1'b0;
      wb_src       = 2'd0;
      illegal      = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model expands each instruction
// into its expected per-cycle trace, which one loop drives and compares against the DUT.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_src, ir_we, pc_we;
  logic [1:0]  pc_src, alu_a_src, alu_op, wb_src;
  logic        alu_b_src, rf_we, illegal;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .alu_op(alu_op), .rf_we(rf_we), .wb_src(wb_src), .state(state), .illegal(illegal)
  );

  typedef struct {
    logic        rst, mem_ready, branch_taken;
    logic [31:0] instr;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_addr_src, ir_we, pc_we;
    logic [1:0]  pc_src, alu_a_src;
    logic        alu_b_src;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_src;
    logic        illegal;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] prev_instr = 32'd0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic cyc_t blank(input logic [31:0] ins);
    cyc_t c;
    c = '{rst: 1'b0, mem_ready: 1'b0, branch_taken: 1'b0, instr: ins, state: 3'd0,
          mem_req: 1'b0, mem_we: 1'b0, mem_addr_src: 1'b0, ir_we: 1'b0, pc_we: 1'b0,
          pc_src: 2'd0, alu_a_src: 2'd0, alu_b_src: 1'b0, alu_op: 2'd0, rf_we: 1'b0,
          wb_src: 2'd0, illegal: 1'b0};
    return c;
  endfunction

  task automatic push_reset(input int n, input logic mr);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(prev_instr);
      c.rst = 1'b1;
      c.mem_ready = mr;
      q.push_back(c);
    end
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic push_instr(input logic [31:0] ins, input int fstall, input int mstall,
                            input logic taken, input int trap_hold);
    cyc_t c;
    logic [6:0] op;
    bit known, is_ls;
    op = ins[6:0];
    known = (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                        7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0001111});
    is_ls = (op == 7'b0000011) || (op == 7'b0100011);
    for (int k = 0; k <= fstall; k++) begin
      c = blank(prev_instr);
      c.mem_req = 1'b1;
      c.mem_ready = (k == fstall);
      c.ir_we = (k == fstall);
      q.push_back(c);
    end
    prev_instr = ins;
    c = blank(ins);
    c.state = 3'd1;
    q.push_back(c);
    if (!known && TRAP_EN) begin
      for (int k = 0; k < trap_hold; k++) begin
        c = blank(ins);
        c.state = 3'd5;
        c.illegal = 1'b1;
        q.push_back(c);
      end
      return;
    end
    c = blank(ins);
    c.state = 3'd2;
    case (op)
      7'b0110011: c.alu_op = 2'd2;
      7'b0010011: begin c.alu_b_src = 1'b1; c.alu_op = 2'd2; end
      7'b0110111: begin c.alu_a_src = 2'd2; c.alu_b_src = 1'b1; end
      7'b0010111, 7'b1101111: begin c.alu_a_src = 2'd1; c.alu_b_src = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0100011: c.alu_b_src = 1'b1;
      7'b1100011: begin
        c.branch_taken = taken;
        c.alu_op = 2'd1;
        c.pc_we = 1'b1;
        c.pc_src = taken ? 2'd1 : 2'd0;
      end
      default: c.pc_we = 1'b1;
    endcase
    q.push_back(c);
    if (c.pc_we) return;
    if (is_ls) begin
      for (int k = 0; k <= mstall; k++) begin
        c = blank(ins);
        c.state = 3'd3;
        c.mem_req = 1'b1;
        c.mem_addr_src = 1'b1;
        c.mem_we = (op == 7'b0100011);
        c.mem_ready = (k == mstall);
        c.pc_we = (k == mstall) && (op == 7'b0100011);
        q.push_back(c);
      end
      if (op == 7'b0100011) return;
    end
    c = blank(ins);
    c.state = 3'd4;
    c.rf_we = (ins[11:7] != 5'd0);
    c.pc_we = 1'b1;
    c.wb_src = (op == 7'b0000011) ? 2'd1 : (op == 7'b1101111 || op == 7'b1100111) ? 2'd2 : 2'd0;
    c.pc_src = (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
    q.push_back(c);
  endtask

  // Drive and check every queued cycle; return the 1-based cycle where the DUT pulsed pc_we (-1 if never).
  task automatic run(output int pcwe_at);
    cyc_t c;
    int n;
    logic [18:0] got, exp;
    n = 0;
    pcwe_at = -1;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst;
      mem_ready = c.mem_ready;
      branch_taken = c.branch_taken;
      instr = c.instr;
      @(negedge clk);
      n++;
      got = {state, mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src, alu_a_src,
             alu_b_src, alu_op, rf_we, wb_src, illegal};
      exp = {c.state, c.mem_req, c.mem_we, c.mem_addr_src, c.ir_we, c.pc_we, c.pc_src,
             c.alu_a_src, c.alu_b_src, c.alu_op, c.rf_we, c.wb_src, c.illegal};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle instr=%08h step=%0d: got %019b required %019b (state..illegal)",
                 c.instr, n, got, exp);
      end else begin
        $display("ok   instr=%08h step=%0d state=%0d", c.instr, n, state);
      end
      if (pc_we === 1'b1 && pcwe_at < 0) pcwe_at = n;
    end
  endtask

  task automatic check_lat(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL latency %s: got %0d required %0d", name, got, req);
    end else begin
      $display("ok   latency %s = %0d", name, got);
    end
  endtask

  initial begin
    push_reset(2, 1'b0);
    run(lat);
    check_lat("reset_no_pcwe", lat, -1);
    push_instr(32'h00500293, 3, 0, 1'b0, 0);   // ADDI x5 after a 3-cycle fetch stall
    run(lat);
    check_lat("fetch_stall_addi", lat, 7);
    push_instr(32'h00500293, 0, 0, 1'b0, 0);
    run(lat);
    check_lat("addi", lat, 4);
    push_instr(32'h00002303, 0, 2, 1'b0, 0);   // LW x6
    run(lat);
    check_lat("lw_mstall2", lat, 7);
    push_instr(32'h00602023, 0, 2, 1'b0, 0);   // SW x6
    run(lat);
    check_lat("sw_mstall2", lat, 6);
    push_instr(32'h00000063, 0, 0, 1'b1, 0);   // BEQ taken
    run(lat);
    check_lat("beq_taken", lat, 3);
    push_instr(32'h00000063, 0, 0, 1'b0, 0);   // BEQ not taken
    run(lat);
    check_lat("beq_not_taken", lat, 3);
    push_instr(32'h008000EF, 0, 0, 1'b0, 0);   // JAL x1
    run(lat);
    check_lat("jal", lat, 4);
    push_instr(32'h00008067, 0, 0, 1'b0, 0);   // JALR x0
    run(lat);
    check_lat("jalr_x0", lat, 4);
    push_instr(32'h002083B3, 1, 0, 1'b0, 0);   // ADD x7
    push_instr(32'h12345437, 0, 0, 1'b0, 0);   // LUI x8
    push_instr(32'h00001497, 0, 0, 1'b0, 0);   // AUIPC x9
    run(lat);
    check_lat("add_first", lat, 5);
    push_instr(32'h0000000F, 0, 0, 1'b0, 0);   // FENCE
    run(lat);
    check_lat("fence", lat, 3);
    push_instr(32'h00002303, 0, 5, 1'b0, 0);   // LW aborted by reset while waiting in MEM
    void'(q.pop_back());
    void'(q.pop_back());
    void'(q.pop_back());
    push_reset(1, 1'b1);
    run(lat);
    check_lat("abort_no_pcwe", lat, -1);
    push_instr(32'h0000007F, 0, 0, 1'b0, 3);   // unknown opcode
    run(lat);
    check_lat("illegal_opcode", lat, TRAP_EN ? -1 : 3);
    push_reset(1, 1'b0);
    push_instr(32'h00500293, 0, 0, 1'b0, 0);
    run(lat);
    check_lat("post_reset_addi", lat, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a shared memory port and a single ALU. It drives every datapath select and write-enable: PC, instruction register, register file, ALU operand muxes and memory request. It decodes the opcode of the latched instruction, which is the same word the immediate extender consumes during DECODE.

## Interface
Parameters: none.
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- instr  in  32  instruction register contents; valid from DECODE onward
- branch_taken  in  1  ALU comparator result for current branch; valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a store
- mem_addr_src  out  1  0 = PC, 1 = ALU result register
- ir_we  out  1  latch fetched word into instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = ALU result register, 2 = {ALU result[31:1], 1'b0}
- alu_a_src  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_src  out  1  0 = rs2, 1 = imm_ext
- alu_op  out  2  0 = add, 1 = branch compare (funct3), 2 = funct3/funct7 decoded
- rf_we  out  1  register file write
- wb_src  out  2  0 = ALU result, 1 = load data, 2 = PC+4
- state  out  3  current state, for debug
- illegal  out  1  illegal-opcode trap indicator

## Operation
State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Outputs are Moore: a function of state and instr[6:0] only, except where noted. Any output not listed for a state is 0.

- **FETCH:** mem_req = 1, mem_addr_src = 0.
  - On mem_ready: ir_we = 1, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** single cycle for register file read and immediate extension; go to EXEC.
  - With the trap feature enabled, an unrecognized opcode goes to TRAP instead.
- **EXEC:**
  - OP (0110011): a = 0, b = 0, alu_op = 2, go to WB.
  - OP_IMM (0010011): a = 0, b = 1, alu_op = 2, go to WB.
  - LUI (0110111): a = 2, b = 1, alu_op = 0, go to WB.
  - AUIPC (0010111): a = 1, b = 1, alu_op = 0, go to WB.
  - JAL (1101111): a = 1, b = 1, alu_op = 0, go to WB.
  - JALR (1100111): a = 0, b = 1, alu_op = 0, go to WB.
  - LOAD (0000011) and STORE (0100011): a = 0, b = 1, alu_op = 0, go to MEM.
  - BRANCH (1100011): a = 0, b = 0, alu_op = 1, pc_we = 1, pc_src = branch_taken ? 1 : 0 (Mealy on branch_taken), go to FETCH. The datapath forms the branch target from PC + imm_ext.
  - FENCE (0001111), and unrecognized opcodes when the trap feature is disabled: pc_we = 1, pc_src = 0, go to FETCH.
- **MEM:** mem_req = 1, mem_addr_src = 1, mem_we = (opcode == STORE).
  - On mem_ready with STORE: pc_we = 1, pc_src = 0, go to FETCH.
  - On mem_ready with LOAD: go to WB.
  - Otherwise stay in MEM.
- **WB:** rf_we = (instr[11:7] != 0). pc_we = 1, go to FETCH.
  - wb_src: LOAD = 1; JAL and JALR = 2; all others = 0.
  - pc_src: JAL = 1; JALR = 2; all others = 0.
- **TRAP:** illegal = 1, all other outputs 0. Stays in TRAP until rst.

## Timing
- Reset: state = FETCH on the clock edge where rst = 1. While rst is high, every output is forced to 0.
- The first cycle after rst deasserts shows mem_req = 1, mem_addr_src = 0.
- Reset mid-operation aborts the instruction:
  - a pending memory request is dropped;
  - no PC, IR or register file write occurs on the reset cycle.
- Latency with mem_ready asserted in the first request cycle:
  - BRANCH and FENCE: 3 cycles.
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each cycle that mem_ready is low adds one cycle.
- mem_req, mem_we and mem_addr_src are stable while waiting. They drop the cycle after mem_ready.
- pc_we is asserted for exactly one cycle per retired instruction, in its final state.
- ir_we is asserted for exactly one cycle per fetch.

## Configuration
- **ILLEGAL_TRAP_EN defined:** an opcode outside the ten listed goes DECODE → TRAP, asserts illegal, and never writes PC or the register file.
- **ILLEGAL_TRAP_EN undefined:** such an opcode retires as a NOP (PC+4, 3 cycles), TRAP is unreachable, and illegal is tied 0. The port exists in both builds.

## Test plan
- Reset then FETCH stall: rst for 2 cycles, mem_ready low for 3 cycles then high.
  - Expect mem_req = 1 for 4 cycles, ir_we pulse on the 4th, state = 1 next.
- ADDI x5 (0x00500293) with mem_ready always high:
  - Expect states 0, 1, 2, 4.
  - EXEC: a = 0, b = 1, alu_op = 2.
  - WB: rf_we = 1, wb_src = 0, pc_we = 1, pc_src = 0.
- LW then SW with mem_ready held low 2 extra MEM cycles:
  - LW: 7 cycles, mem_we = 0, WB wb_src = 1.
  - SW: 6 cycles, mem_we = 1 throughout MEM, no rf_we.
- BEQ with branch_taken = 1 then 0:
  - Expect pc_src = 1 then 0 in EXEC, 3 cycles each, no rf_we.
- JAL x1 and JALR x0:
  - JAL: wb_src = 2, pc_src = 1, rf_we = 1.
  - JALR x0: pc_src = 2, rf_we = 0.
- Opcode 0x7F:
  - With ILLEGAL_TRAP_EN: state = 5, illegal = 1, held until rst; rst returns state to 0.
  - Without ILLEGAL_TRAP_EN: NOP, pc_we pulse in EXEC.
